branch_predictor: RTL and testbench
===================================

# branch_predictor

Parametrised branch target buffer with 2-bit saturating direction counters for the 5-stage pipelined MIPS core. The IF stage looks up the fetch PC combinationally and receives a predicted next PC. The EX stage writes back each resolved conditional branch. The block also keeps saturating statistics counters, readable by software through the peripheral bus glue.

## Interface

Parameters:
- ENTRIES, 16: number of direct-mapped entries; power of two, 2..256. IDX_W = log2(ENTRIES).
- ADDR_W, 32: PC width.
- CNT_W, 16: width of each statistics counter.
- SKIP_KERNEL, 1: when 1, PCs with bit ADDR_W-1 set (kernel mode) never hit and never allocate.

Ports:
- clk, input, 1: clock; all state changes on the rising edge.
- reset, input, 1: reset, asynchronous, active-low.
- if_pc, input, ADDR_W: fetch PC to look up.
- pred_hit, output, 1: valid entry with matching tag for if_pc.
- pred_taken, output, 1: pred_hit & counter[1].
- pred_target, output, ADDR_W: stored target if pred_taken, else if_pc + 4.
- upd_valid, input, 1: one-cycle strobe; a conditional branch resolved in EX.
- upd_pc, input, ADDR_W: PC of the resolved branch.
- upd_taken, input, 1: actual branch outcome.
- upd_target, input, ADDR_W: actual branch target (ConBA).
- flush_all, input, 1: invalidate every entry.
- stat_clr, input, 1: zero both statistics counters.
- stat_updates, output, CNT_W: number of accepted updates.
- stat_mispred, output, CNT_W: number of mispredicted updates.

## Operation

- Per entry: valid (1b), tag (ADDR_W-IDX_W-2 bits), target (ADDR_W), ctr (2b). Index = pc[IDX_W+1:2]; tag = pc[ADDR_W-1:IDX_W+2]; pc[1:0] is ignored.
- Lookup is purely combinational from if_pc and the current table. It does not bypass a same-cycle update.
- Kernel filter: if SKIP_KERNEL=1 and pc[ADDR_W-1]=1:
  - the lookup misses;
  - an update is ignored entirely (no table change, no statistics).
- Prediction at update time: compute the prediction for upd_pc from the current table, using the lookup rule.
- Mispredict: the predicted direction differs from upd_taken, or both say taken but the stored target differs from upd_target.
- Update on an accepted upd_valid:
  - Hit, taken: ctr saturating increment (max 3); target <= upd_target.
  - Hit, not taken: ctr saturating decrement (min 0); target unchanged.
  - Miss, taken: allocate (overwrite any occupant): valid=1, tag, target=upd_target, ctr=2'b10.
  - Miss, not taken: no table change.
- Statistics on an accepted update:
  - stat_updates += 1.
  - stat_mispred += 1 if mispredicted.
  - Both counters saturate at all-ones and never wrap.
- Priority:
  - flush_all clears all valid bits and suppresses a same-cycle table update. Statistics still count that update.
  - stat_clr zeros both counters and suppresses a same-cycle increment.
- Aliasing: two PCs with the same index and different tags evict each other. Only the tag decides a hit.

## Timing

- Reset (asynchronous, reset=0):
  - all valid = 0, ctr = 2'b01, target = 0, statistics = 0.
  - Outputs: pred_hit=0, pred_taken=0, pred_target=if_pc+4, stat_updates=0, stat_mispred=0.
- Lookup latency: 0 cycles (combinational).
- Update latency: table and statistics change at the rising edge where upd_valid=1. The new contents are visible to lookup in the following cycle.
- Same-cycle lookup and update of the same entry: lookup returns the pre-update contents.
- Reset asserted mid-operation clears state immediately, regardless of clk. Inputs are ignored while reset=0.
- Upstream may assert upd_valid every cycle; there is no backpressure.

## Test plan

- Reset state: after reset, any if_pc (e.g. 0x0000_0040) -> pred_hit=0, pred_taken=0, pred_target=0x0000_0044; both statistics = 0.
- Allocate and strengthen:
  - Update pc=0x0000_0040, taken, target=0x0000_0010 -> next cycle if_pc=0x40 gives hit=1, taken=1, target=0x10; stat_updates=1, stat_mispred=1.
  - Repeat the update -> ctr=3, mispred stays 1.
- Hysteresis: from ctr=3, two not-taken updates -> after the first, still taken (ctr=2); after the second, pred_taken=0, pred_target=0x44, pred_hit=1; the second counts as a mispredict.
- Aliasing and kernel filter (ENTRIES=16):
  - Entry at 0x0000_0040, then a taken update at 0x0000_0080 -> 0x40 misses, 0x80 hits.
  - Update at 0x8000_0040 -> table and statistics unchanged; lookup of 0x8000_0040 misses.
- Simultaneous events:
  - Same-cycle lookup and update of 0x40 -> lookup shows the old contents.
  - flush_all with upd_valid -> all entries invalid next cycle, stat_updates still incremented.
  - stat_clr with upd_valid -> statistics read 0.
- Saturation (CNT_W=4): 20 consecutive mispredicting updates -> stat_updates=15, stat_mispred=15, no wrap; asynchronous reset mid-stream -> all outputs return to reset values before the next edge.

Source files
------------

// File: rtl/branch_predictor.sv
// Direct-mapped branch target buffer with 2-bit saturating direction counters.
// The IF stage looks up the fetch PC combinationally and gets a predicted next
// PC. Resolved conditional branches from EX train the table. Two saturating
// statistics counters track accepted updates and mispredictions.
//
// Update handshake: upd_valid is a one-cycle strobe with no ready. Every cycle
// in which upd_valid=1 carries exactly one resolved branch. It takes effect at
// that rising edge and is visible to lookup from the next cycle on.
module branch_predictor #(
   parameter int ENTRIES     = 16,
   parameter int ADDR_W      = 32,
   parameter int CNT_W       = 16,
   parameter int SKIP_KERNEL = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [ADDR_W-1:0] if_pc,
   output logic              pred_hit,
   output logic              pred_taken,
   output logic [ADDR_W-1:0] pred_target,
   input  logic              upd_valid,
   input  logic [ADDR_W-1:0] upd_pc,
   input  logic              upd_taken,
   input  logic [ADDR_W-1:0] upd_target,
   input  logic              flush_all,
   input  logic              stat_clr,
   output logic [CNT_W-1:0]  stat_updates,
   output logic [CNT_W-1:0]  stat_mispred
);

   localparam int IDX_W = $clog2(ENTRIES);
   localparam int TAG_W = ADDR_W - IDX_W - 2;
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [ENTRIES-1:0] valid_q, valid_d;
   logic [TAG_W-1:0]   tag_q    [ENTRIES];
   logic [TAG_W-1:0]   tag_d    [ENTRIES];
   logic [ADDR_W-1:0]  target_q [ENTRIES];
   logic [ADDR_W-1:0]  target_d [ENTRIES];
   logic [1:0]         ctr_q    [ENTRIES];
   logic [1:0]         ctr_d    [ENTRIES];
   logic [CNT_W-1:0]   upd_cnt_q, upd_cnt_d;
   logic [CNT_W-1:0]   mis_cnt_q, mis_cnt_d;

   // The byte offset of a PC never affects indexing or tagging.
   logic unused_pc_bits;
   assign unused_pc_bits = ^{if_pc[1:0], upd_pc[1:0]};

   // Fetch-side lookup: combinational from the current table, no bypass.
   logic [IDX_W-1:0] if_idx;
   logic [TAG_W-1:0] if_tag;
   logic             if_kernel;
   assign if_idx    = if_pc[IDX_W+1:2];
   assign if_tag    = if_pc[ADDR_W-1:IDX_W+2];
   assign if_kernel = (SKIP_KERNEL != 0) && if_pc[ADDR_W-1];

   assign pred_hit    = valid_q[if_idx] && (tag_q[if_idx] == if_tag) && !if_kernel;
   assign pred_taken  = pred_hit && ctr_q[if_idx][1];
   assign pred_target = pred_taken ? target_q[if_idx] : (if_pc + ADDR_W'(4));

   // Update-side prediction uses the same rule as fetch, on upd_pc.
   logic [IDX_W-1:0] u_idx;
   logic [TAG_W-1:0] u_tag;
   logic             u_kernel;
   logic             u_accept;
   logic             u_hit;
   logic             u_pred_taken;
   logic             u_mispred;
   assign u_idx        = upd_pc[IDX_W+1:2];
   assign u_tag        = upd_pc[ADDR_W-1:IDX_W+2];
   assign u_kernel     = (SKIP_KERNEL != 0) && upd_pc[ADDR_W-1];
   assign u_accept     = upd_valid && !u_kernel;
   assign u_hit        = valid_q[u_idx] && (tag_q[u_idx] == u_tag) && !u_kernel;
   assign u_pred_taken = u_hit && ctr_q[u_idx][1];
   assign u_mispred    = (u_pred_taken != upd_taken) ||
                         (u_pred_taken && upd_taken && (target_q[u_idx] != upd_target));

   assign stat_updates = upd_cnt_q;
   assign stat_mispred = mis_cnt_q;

   // Next table contents: flush wins over training, misses allocate only when taken.
   always_comb begin
      valid_d  = valid_q;
      tag_d    = tag_q;
      target_d = target_q;
      ctr_d    = ctr_q;
      if (flush_all) begin
         valid_d = '0;
      end else if (u_accept) begin
         if (u_hit) begin
            if (upd_taken) begin
               if (ctr_q[u_idx] != 2'b11) ctr_d[u_idx] = ctr_q[u_idx] + 2'd1;
               target_d[u_idx] = upd_target;
            end else if (ctr_q[u_idx] != 2'b00) begin
               ctr_d[u_idx] = ctr_q[u_idx] - 2'd1;
            end
         end else if (upd_taken) begin
            valid_d[u_idx]  = 1'b1;
            tag_d[u_idx]    = u_tag;
            target_d[u_idx] = upd_target;
            ctr_d[u_idx]    = 2'b10;
         end
      end
   end

   // Next statistics: clear wins over counting, both saturate at all-ones.
   always_comb begin
      upd_cnt_d = upd_cnt_q;
      mis_cnt_d = mis_cnt_q;
      if (stat_clr) begin
         upd_cnt_d = '0;
         mis_cnt_d = '0;
      end else if (u_accept) begin
         if (upd_cnt_q != CNT_MAX) upd_cnt_d = upd_cnt_q + CNT_W'(1);
         if (u_mispred && (mis_cnt_q != CNT_MAX)) mis_cnt_d = mis_cnt_q + CNT_W'(1);
      end
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         valid_q   <= '0;
         upd_cnt_q <= '0;
         mis_cnt_q <= '0;
         for (int i = 0; i < ENTRIES; i++) begin
            tag_q[i]    <= '0;
            target_q[i] <= '0;
            ctr_q[i]    <= 2'b01;
         end
      end else begin
         valid_q   <= valid_d;
         upd_cnt_q <= upd_cnt_d;
         mis_cnt_q <= mis_cnt_d;
         for (int i = 0; i < ENTRIES; i++) begin
            tag_q[i]    <= tag_d[i];
            target_q[i] <= target_d[i];
            ctr_q[i]    <= ctr_d[i];
         end
      end
   end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed bench for branch_predictor (ENTRIES=16, ADDR_W=32, CNT_W=4).
// Each step drives one cycle of inputs and queues the outputs expected in that
// cycle (pre-edge view); a monitor on the falling edge pops and compares.
module tb_branch_predictor;

   localparam int W = 42;  // hit, taken, target[31:0], updates[3:0], mispred[3:0]

   logic        clk;
   logic        reset;
   logic [31:0] if_pc;
   logic        pred_hit;
   logic        pred_taken;
   logic [31:0] pred_target;
   logic        upd_valid;
   logic [31:0] upd_pc;
   logic        upd_taken;
   logic [31:0] upd_target;
   logic        flush_all;
   logic        stat_clr;
   logic [3:0]  stat_updates;
   logic [3:0]  stat_mispred;

   logic [W-1:0] exp_q[$];
   string        name_q[$];
   int           checks;
   int           errors;

   branch_predictor #(
      .ENTRIES(16), .ADDR_W(32), .CNT_W(4), .SKIP_KERNEL(1)
   ) dut (
      .clk(clk), .reset(reset), .if_pc(if_pc),
      .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
      .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
      .upd_target(upd_target), .flush_all(flush_all), .stat_clr(stat_clr),
      .stat_updates(stat_updates), .stat_mispred(stat_mispred)
   );

   // Clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Scoreboard compare helper
   task automatic chk(input string nm, input string fld, input logic [31:0] act,
                      input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s.%s actual=%h required=%h", nm, fld, act, req);
      end
   endtask

   // Monitor: outputs are observed every falling edge that has an expectation.
   always @(negedge clk) begin
      if (exp_q.size() != 0) begin
         logic [W-1:0] e;
         string        nm;
         e  = exp_q.pop_front();
         nm = name_q.pop_front();
         chk(nm, "hit",     {31'd0, pred_hit},     {31'd0, e[41]});
         chk(nm, "taken",   {31'd0, pred_taken},   {31'd0, e[40]});
         chk(nm, "target",  pred_target,           e[39:8]);
         chk(nm, "updates", {28'd0, stat_updates}, {28'd0, e[7:4]});
         chk(nm, "mispred", {28'd0, stat_mispred}, {28'd0, e[3:0]});
      end
   end

   task automatic drive(input logic [31:0] pc, input logic uv, input logic [31:0] upc,
                        input logic ut, input logic [31:0] utgt, input logic fl,
                        input logic cl);
      if_pc      = pc;
      upd_valid  = uv;
      upd_pc     = upc;
      upd_taken  = ut;
      upd_target = utgt;
      flush_all  = fl;
      stat_clr   = cl;
   endtask

   task automatic expect_out(input logic e_hit, input logic e_tk, input logic [31:0] e_tgt,
                             input logic [3:0] e_u, input logic [3:0] e_m, input string nm);
      exp_q.push_back({e_hit, e_tk, e_tgt, e_u, e_m});
      name_q.push_back(nm);
   endtask

   // One cycle: drive, queue the expected outputs for this cycle, cross the edge.
   task automatic step(input logic [31:0] pc, input logic uv, input logic [31:0] upc,
                       input logic ut, input logic [31:0] utgt, input logic fl,
                       input logic cl, input logic e_hit, input logic e_tk,
                       input logic [31:0] e_tgt, input logic [3:0] e_u,
                       input logic [3:0] e_m, input string nm);
      drive(pc, uv, upc, ut, utgt, fl, cl);
      expect_out(e_hit, e_tk, e_tgt, e_u, e_m, nm);
      @(posedge clk);
      #1;
   endtask

   // Stimulus
   initial begin
      checks = 0;
      errors = 0;
      reset  = 1'b0;
      drive(32'h40, 0, 0, 0, 0, 0, 0);
      repeat (2) @(posedge clk);
      #1 reset = 1'b1;

      //    if_pc       uv upd_pc      ut upd_tgt     fl cl  hit tk target      upd mis
      step(32'h40,      0, 32'h0,      0, 32'h0,      0, 0,  0, 0, 32'h44,      0, 0, "reset");
      step(32'h40,      1, 32'h40,     1, 32'h10,     0, 0,  0, 0, 32'h44,      0, 0, "alloc_same_cyc");
      step(32'h40,      1, 32'h40,     1, 32'h10,     0, 0,  1, 1, 32'h10,      1, 1, "alloc_hit");
      step(32'h40,      1, 32'h40,     0, 32'h0,      0, 0,  1, 1, 32'h10,      2, 1, "ctr3");
      step(32'h40,      1, 32'h40,     0, 32'h0,      0, 0,  1, 1, 32'h10,      3, 2, "hyst_first");
      step(32'h40,      0, 32'h0,      0, 32'h0,      0, 0,  1, 0, 32'h44,      4, 3, "hyst_second");
      step(32'h40,      1, 32'h40,     0, 32'h0,      0, 0,  1, 0, 32'h44,      4, 3, "nt_correct");
      step(32'h40,      1, 32'h80,     1, 32'h200,    0, 0,  1, 0, 32'h44,      5, 3, "alias_upd");
      step(32'h40,      0, 32'h0,      0, 32'h0,      0, 0,  0, 0, 32'h44,      6, 4, "alias_evict");
      step(32'h80,      0, 32'h0,      0, 32'h0,      0, 0,  1, 1, 32'h200,     6, 4, "alias_hit");
      step(32'h80000040,1, 32'h80000040,1, 32'h300,   0, 0,  0, 0, 32'h80000044,6, 4, "kernel_miss");
      step(32'h80,      0, 32'h0,      0, 32'h0,      0, 0,  1, 1, 32'h200,     6, 4, "kernel_nochg");
      step(32'h80,      1, 32'h80,     1, 32'h204,    0, 0,  1, 1, 32'h200,     6, 4, "tgt_mispred");
      step(32'h80,      1, 32'h44,     1, 32'h50,     0, 0,  1, 1, 32'h204,     7, 5, "tgt_updated");
      step(32'h44,      1, 32'h80,     1, 32'h204,    1, 0,  1, 1, 32'h50,      8, 6, "flush_upd");
      step(32'h80,      0, 32'h0,      0, 32'h0,      0, 0,  0, 0, 32'h84,      9, 6, "flush_a");
      step(32'h44,      1, 32'h44,     1, 32'h50,     0, 1,  0, 0, 32'h48,      9, 6, "clr_upd");
      step(32'h44,      0, 32'h0,      0, 32'h0,      0, 0,  1, 1, 32'h50,      0, 0, "clr_zero");

      // Twenty alternating aliasing updates: every one misses and mispredicts.
      for (int i = 0; i < 20; i++) begin
         logic [3:0] s;
         s = (i < 15) ? i[3:0] : 4'hf;
         step(32'h48, 1, ((i % 2) == 0) ? 32'h100 : 32'h140, 1, 32'h20, 0, 0,
              0, 0, 32'h4c, s, s, "sat_run");
      end
      step(32'h140, 0, 32'h0, 0, 32'h0, 0, 0, 1, 1, 32'h20, 4'hf, 4'hf, "sat_end");

      // Asynchronous reset between edges, with an update still being driven.
      drive(32'h140, 1, 32'h100, 1, 32'h20, 0, 0);
      expect_out(0, 0, 32'h144, 0, 0, "async_reset");
      #2 reset = 1'b0;
      @(posedge clk);
      #1 reset = 1'b1;
      step(32'h140, 0, 32'h0, 0, 32'h0, 0, 0, 0, 0, 32'h144, 0, 0, "post_reset");

      for (int n = 0; n < 10 && exp_q.size() != 0; n++) @(posedge clk);
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain pending=%0d required=0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
